// File: rtl/spart_driver_if.sv
// Host and SPART control signals seen by spart_driver. The 8-bit tri-state
// data bus stays a plain inout port on the driver.
interface spart_driver_if;
    logic [1:0] br_cfg;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       cfg_done;

    modport master (
        input  br_cfg, rda, tbr, tx_req, tx_data,
        output iocs, iorw, ioaddr, tx_ack, rx_valid, rx_data, cfg_done
    );

    modport slave (
        output br_cfg, rda, tbr, tx_req, tx_data,
        input  iocs, iorw, ioaddr, tx_ack, rx_valid, rx_data, cfg_done
    );
endinterface

// File: rtl/spart_driver.sv
// SPART bus-master sequencer: programs the baud divisor, then moves received
// bytes to the host (optionally echoing them) and host bytes to the transmitter.
module spart_driver #(
    parameter logic [15:0] DIV_4800  = 16'd1301,
    parameter logic [15:0] DIV_9600  = 16'd650,
    parameter logic [15:0] DIV_19200 = 16'd325,
    parameter logic [15:0] DIV_38400 = 16'd162,
    parameter bit          ECHO      = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    spart_driver_if.master bus,
    inout  wire  [7:0]     databus
);
    typedef enum logic [2:0] {
        ST_CFG_LO  = 3'd0,
        ST_CFG_HI  = 3'd1,
        ST_CFG_FIN = 3'd2,
        ST_RUN     = 3'd3,
        ST_RD      = 3'd4,
        ST_WR_ECHO = 3'd5,
        ST_WR_HOST = 3'd6
    } state_t;

    state_t     r_state;
    logic       r_iocs;
    logic       r_iorw;
    logic [1:0] r_ioaddr;
    logic [7:0] r_dout;
    logic       r_tx_ack;
    logic       r_rx_valid;
    logic [7:0] r_rx_data;
    logic       r_cfg_done;
    logic       r_echo_pend;
    logic [7:0] r_echo_buf;
    logic [1:0] r_br_q;

    function automatic logic [7:0] div_byte(input logic [1:0] br, input logic hi);
        logic [15:0] div;
        case (br)
            2'b00:   div = DIV_4800;
            2'b01:   div = DIV_9600;
            2'b10:   div = DIV_19200;
            default: div = DIV_38400;
        endcase
        div_byte = hi ? div[15:8] : div[7:0];
    endfunction

    // Drive enable comes straight from registers so an async reset releases the bus at once.
    assign databus      = (r_iocs && !r_iorw) ? r_dout : 8'hzz;
    assign bus.iocs     = r_iocs;
    assign bus.iorw     = r_iorw;
    assign bus.ioaddr   = r_ioaddr;
    assign bus.tx_ack   = r_tx_ack;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_data  = r_rx_data;
    assign bus.cfg_done = r_cfg_done;

    // Sequencer: each access state holds the bus for one cycle, then RUN idles a cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_CFG_LO;
            r_iocs      <= 1'b0;
            r_iorw      <= 1'b1;
            r_ioaddr    <= 2'b00;
            r_dout      <= 8'h00;
            r_tx_ack    <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= 8'h00;
            r_cfg_done  <= 1'b0;
            r_echo_pend <= 1'b0;
            r_echo_buf  <= 8'h00;
            r_br_q      <= bus.br_cfg;
        end else begin
            r_tx_ack   <= 1'b0;
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_CFG_LO: begin
                    r_iocs   <= 1'b1;
                    r_iorw   <= 1'b0;
                    r_ioaddr <= 2'b10;
                    r_dout   <= div_byte(bus.br_cfg, 1'b0);
                    r_br_q   <= bus.br_cfg;
                    r_state  <= ST_CFG_HI;
                end
                ST_CFG_HI: begin
                    r_iocs   <= 1'b1;
                    r_iorw   <= 1'b0;
                    r_ioaddr <= 2'b11;
                    r_dout   <= div_byte(r_br_q, 1'b1);
                    r_state  <= ST_CFG_FIN;
                end
                ST_CFG_FIN: begin
                    r_iocs     <= 1'b0;
                    r_iorw     <= 1'b1;
                    r_ioaddr   <= 2'b00;
                    r_cfg_done <= 1'b1;
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.br_cfg != r_br_q) begin
                        r_cfg_done <= 1'b0;
                        r_state    <= ST_CFG_LO;
                    end else if (r_echo_pend && bus.tbr) begin
                        r_iocs   <= 1'b1;
                        r_iorw   <= 1'b0;
                        r_ioaddr <= 2'b00;
                        r_dout   <= r_echo_buf;
                        r_state  <= ST_WR_ECHO;
                    end else if (bus.rda && !r_echo_pend) begin
                        r_iocs   <= 1'b1;
                        r_iorw   <= 1'b1;
                        r_ioaddr <= 2'b00;
                        r_state  <= ST_RD;
                    end else if (bus.tx_req && bus.tbr && !r_echo_pend) begin
                        r_iocs   <= 1'b1;
                        r_iorw   <= 1'b0;
                        r_ioaddr <= 2'b00;
                        r_dout   <= bus.tx_data;
                        r_tx_ack <= 1'b1;
                        r_state  <= ST_WR_HOST;
                    end else begin
                        r_state  <= ST_RUN;
                    end
                end
                ST_RD: begin
                    r_rx_data  <= databus;
                    r_rx_valid <= 1'b1;
                    if (ECHO) begin
                        r_echo_buf  <= databus;
                        r_echo_pend <= 1'b1;
                    end else begin
                        r_echo_pend <= 1'b0;
                    end
                    r_iocs   <= 1'b0;
                    r_iorw   <= 1'b1;
                    r_ioaddr <= 2'b00;
                    r_state  <= ST_RUN;
                end
                ST_WR_ECHO: begin
                    r_echo_pend <= 1'b0;
                    r_iocs      <= 1'b0;
                    r_iorw      <= 1'b1;
                    r_ioaddr    <= 2'b00;
                    r_state     <= ST_RUN;
                end
                ST_WR_HOST: begin
                    r_iocs   <= 1'b0;
                    r_iorw   <= 1'b1;
                    r_ioaddr <= 2'b00;
                    r_state  <= ST_RUN;
                end
                default: begin
                    r_iocs     <= 1'b0;
                    r_iorw     <= 1'b1;
                    r_ioaddr   <= 2'b00;
                    r_cfg_done <= 1'b0;
                    r_state    <= ST_CFG_LO;
                end
            endcase
        end
    end
endmodule
